// File: rtl/zled_multi_indicator.sv
// Multi-channel LED indicator: per-channel off/on/breathe/event-flash driven by
// a shared tick prescaler, PWM counter and triangular breathe ramp.
module zled_multi_indicator #(
  parameter int unsigned TICK_DIV   = 50,
  parameter int unsigned PWM_MAX    = 1000,
  parameter int unsigned STRETCH    = 100,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input  logic                  iClk,
  input  logic                  iRst_N,
  input  logic [2*NUM_CH-1:0]   iMode,
  input  logic [NUM_CH-1:0]     iEvent,
  output logic [NUM_CH-1:0]     oLED
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = $clog2(PWM_MAX);
  localparam int unsigned SW = $clog2(STRETCH + 1);
  localparam logic [NUM_CH-1:0] DARK = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [TW-1:0]     tickCnt;
  logic [PW-1:0]     pwmCnt;
  logic [PW-1:0]     lvl;
  logic              dirDown;
  logic [NUM_CH-1:0] evD;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] lit;
  logic              tick;
  logic              periodEnd;

  assign tick      = (tickCnt == TW'(TICK_DIV - 1));
  assign periodEnd = tick && (pwmCnt == PW'(PWM_MAX - 1));
  assign rise      = iEvent & ~evD;

  // Shared prescaler and PWM counter; free-running, untouched by mode changes
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      tickCnt <= '0;
      pwmCnt  <= '0;
    end else begin
      tickCnt <= tick ? '0 : tickCnt + TW'(1);
      if (tick) begin
        pwmCnt <= (pwmCnt == PW'(PWM_MAX - 1)) ? '0 : pwmCnt + PW'(1);
      end
    end
  end

  // Triangular ramp; direction flips on reaching an end so no level repeats
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      lvl     <= '0;
      dirDown <= 1'b0;
    end else if (periodEnd) begin
      if (!dirDown) begin
        lvl <= lvl + PW'(1);
        if (lvl == PW'(PWM_MAX - 2)) dirDown <= 1'b1;
      end else begin
        lvl <= lvl - PW'(1);
        if (lvl == PW'(1)) dirDown <= 1'b0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) evD <= '0;
    else         evD <= iEvent;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    logic [1:0]    mode;
    logic [SW-1:0] stCnt;

    assign mode = iMode[2*i +: 2];

    // Reload on rise wins over the period-end decrement, giving retrigger
    always_ff @(posedge iClk or negedge iRst_N) begin
      if (!iRst_N) begin
        stCnt <= '0;
      end else if (mode != 2'b11) begin
        stCnt <= '0;
      end else if (rise[i]) begin
        stCnt <= SW'(STRETCH);
      end else if (periodEnd && (stCnt != '0)) begin
        stCnt <= stCnt - SW'(1);
      end
    end

    assign lit[i] = (mode == 2'b01) ||
                    ((mode == 2'b10) && (pwmCnt < lvl)) ||
                    ((mode == 2'b11) && (stCnt != '0));
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) oLED <= DARK;
    else         oLED <= lit ^ DARK;
  end

endmodule

// File: tb/tb_zled_multi_indicator.sv
// Directed bench for zled_multi_indicator with TICK_DIV=2, PWM_MAX=4, STRETCH=3,
// two channels; an ACTIVE_LOW=1 copy shares the same stimulus.
module tb_zled_multi_indicator;

  logic       iClk = 1'b0;
  logic       iRst_N;
  logic [3:0] iMode;
  logic [1:0] iEvent;
  logic [1:0] led;
  logic [1:0] ledAl;

  int nTests = 0;
  int nFail  = 0;

  always #5 iClk = ~iClk;

  zled_multi_indicator #(
    .TICK_DIV(2), .PWM_MAX(4), .STRETCH(3), .NUM_CH(2), .ACTIVE_LOW(0)
  ) dut (
    .iClk(iClk), .iRst_N(iRst_N), .iMode(iMode), .iEvent(iEvent), .oLED(led)
  );

  zled_multi_indicator #(
    .TICK_DIV(2), .PWM_MAX(4), .STRETCH(3), .NUM_CH(2), .ACTIVE_LOW(1)
  ) dutAl (
    .iClk(iClk), .iRst_N(iRst_N), .iMode(iMode), .iEvent(iEvent), .oLED(ledAl)
  );

  // Advance one clock edge; inputs are driven and outputs sampled on the falling edge
  task automatic step();
    @(negedge iClk);
  endtask

  // Leaves the bench on the falling edge just after release (edge 0 reference)
  task automatic doReset();
    iRst_N = 1'b0;
    iEvent = '0;
    iMode  = '0;
    step();
    step();
    iRst_N = 1'b1;
  endtask

  task automatic test_reset();
    iRst_N = 1'b0;
    iEvent = '0;
    iMode  = '0;
    step();
    nTests++;
    if (led !== 2'b00) begin
      nFail++;
      $display("FAIL reset_led got=%b exp=%b", led, 2'b00);
    end
    nTests++;
    if (ledAl !== 2'b11) begin
      nFail++;
      $display("FAIL reset_led_al got=%b exp=%b", ledAl, 2'b11);
    end
    iRst_N = 1'b1;
    iMode  = 4'b0001;
    for (int e = 1; e <= 10; e++) begin
      step();
      nTests++;
      if (led !== 2'b01 || ledAl !== 2'b10) begin
        nFail++;
        $display("FAIL mode_on e=%0d got=%b/%b exp=01/10", e, led, ledAl);
      end
    end
  endtask

  task automatic test_breathe();
    int expLit [6] = '{0, 2, 4, 6, 4, 2};
    doReset();
    iMode = 4'b1010;
    for (int p = 0; p < 12; p++) begin
      int cnt = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (led[0]) cnt++;
        nTests++;
        if (led[0] !== led[1]) begin
          nFail++;
          $display("FAIL breathe_lock p=%0d k=%0d got=%b", p, k, led);
        end
      end
      nTests++;
      if (cnt != expLit[p % 6]) begin
        nFail++;
        $display("FAIL breathe_duty p=%0d got=%0d exp=%0d", p, cnt, expLit[p % 6]);
      end
    end
  endtask

  task automatic test_flash();
    logic ex;
    doReset();
    iMode = 4'b0011;
    for (int e = 1; e <= 30; e++) begin
      step();
      ex = (e >= 5 && e <= 24);
      nTests++;
      if (led !== {1'b0, ex}) begin
        nFail++;
        $display("FAIL flash e=%0d got=%b exp=%b", e, led, {1'b0, ex});
      end
      if (e == 3) iEvent = 2'b01;
      if (e == 4) iEvent = 2'b00;
    end
  endtask

  task automatic test_retrigger();
    logic ex;
    doReset();
    iMode = 4'b0011;
    // Second rise lands on the period_end at edge 16: reload wins
    for (int e = 1; e <= 45; e++) begin
      step();
      ex = (e >= 5 && e <= 40);
      nTests++;
      if (led !== {1'b0, ex}) begin
        nFail++;
        $display("FAIL retrigger e=%0d got=%b exp=%b", e, led, {1'b0, ex});
      end
      if (e == 3 || e == 15) iEvent = 2'b01;
      if (e == 4 || e == 16) iEvent = 2'b00;
    end
    doReset();
    iMode = 4'b0011;
    for (int e = 1; e <= 50; e++) begin
      step();
      ex = (e >= 5 && e <= 24);
      nTests++;
      if (led !== {1'b0, ex}) begin
        nFail++;
        $display("FAIL held_event e=%0d got=%b exp=%b", e, led, {1'b0, ex});
      end
      if (e == 3)  iEvent = 2'b01;
      if (e == 43) iEvent = 2'b00;
    end
  endtask

  task automatic test_mode_clear();
    logic ex;
    doReset();
    iMode = 4'b0011;
    for (int e = 1; e <= 30; e++) begin
      step();
      ex = (e >= 5 && e <= 10);
      nTests++;
      if (led !== {1'b0, ex}) begin
        nFail++;
        $display("FAIL mode_clear e=%0d got=%b exp=%b", e, led, {1'b0, ex});
      end
      if (e == 3)  iEvent = 2'b01;
      if (e == 4)  iEvent = 2'b00;
      if (e == 10) iMode  = 4'b0000;
      if (e == 14) iMode  = 4'b0011;
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    iMode = 4'b1011;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 3) iEvent = 2'b01;
      if (e == 4) iEvent = 2'b00;
    end
    nTests++;
    if (ledAl !== 2'b00) begin
      nFail++;
      $display("FAIL pre_reset_lit got=%b exp=%b", ledAl, 2'b00);
    end
    iRst_N = 1'b0;
    #1;
    nTests++;
    if (ledAl !== 2'b11) begin
      nFail++;
      $display("FAIL async_reset_al got=%b exp=%b", ledAl, 2'b11);
    end
    nTests++;
    if (led !== 2'b00) begin
      nFail++;
      $display("FAIL async_reset got=%b exp=%b", led, 2'b00);
    end
    step();
    step();
    iRst_N = 1'b1;
    iMode  = 4'b1010;
    for (int p = 0; p < 3; p++) begin
      int cnt = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (!ledAl[0]) cnt++;
        nTests++;
        if (ledAl[0] !== ledAl[1]) begin
          nFail++;
          $display("FAIL restart_lock p=%0d k=%0d got=%b", p, k, ledAl);
        end
      end
      nTests++;
      if (cnt != 2 * p) begin
        nFail++;
        $display("FAIL restart_duty p=%0d got=%0d exp=%0d", p, cnt, 2 * p);
      end
    end
  endtask

  initial begin
    iRst_N = 1'b0;
    iMode  = '0;
    iEvent = '0;
    test_reset();
    test_breathe();
    test_flash();
    test_retrigger();
    test_mode_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
